hp_rd_dma: RTL and testbench

//  Read-DMA engine driving the 128b/48b AXI4 HP read channel toward the NVMe driver.
//  - Accepts one command (start address, length in 16B beats).
//  - Splits it into INCR bursts that never cross a 4KiB boundary.
//  - Streams returned data out on an AXI-Stream master.
//  - Sits inside the kernel, directly upstream of the hp_ar*/hp_r* master ports.

---
 rtl/hp_rd_dma.sv | 141 ++++++++++++++
 tb/tb_hp_rd_dma.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_rd_dma.sv
// Read-DMA engine: one command -> 4KiB-safe INCR bursts on the HP AR/R
// channel, with the returned data streamed out on an AXI-Stream master.
// Ports: clk/rst, cmd_* (command in), busy/done/err (status),
// hp_ar*/hp_r* (AXI4 read master), m_t* (stream master).
// Optional macro HP_RD_DMA_ERR_EN: sticky error flag from hp_rresp.
module hp_rd_dma #(
  parameter int HP_ADDR_WIDTH = 48,
  parameter int HP_DATA_WIDTH = 128,
  parameter int LEN_WIDTH     = 20,
  parameter int MAX_BURST     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [HP_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]     cmd_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [HP_ADDR_WIDTH-1:0] hp_araddr,
  output logic [7:0]               hp_arlen,
  output logic [2:0]               hp_arsize,
  output logic [1:0]               hp_arburst,
  output logic                     hp_arvalid,
  input  logic                     hp_arready,
  input  logic [HP_DATA_WIDTH-1:0] hp_rdata,
  input  logic [1:0]               hp_rresp,
  input  logic                     hp_rlast,
  input  logic                     hp_rvalid,
  output logic                     hp_rready,
  output logic [HP_DATA_WIDTH-1:0] m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic                     m_tlast
);

  typedef enum logic [1:0] {
    IDLE, AR, DATA, DONE
  } state_t;

  localparam logic [8:0] CAP = 9'(MAX_BURST);

  state_t                   state, state_nx;
  logic [HP_ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]     rem;
  logic [8:0]               room, lim, blen, arlen_w;
  logic                     accept, ar_fire, beat;

  // Beats left before the next 4KiB boundary.
  assign room = 9'd256 - {1'b0, addr[11:4]};
  assign lim  = (room < CAP) ? room : CAP;
  assign blen = (rem < LEN_WIDTH'(lim)) ? rem[8:0] : lim;
  assign arlen_w = blen - 9'd1;

  assign hp_araddr  = addr;
  assign hp_arlen   = arlen_w[7:0];
  assign hp_arsize  = 3'b100;
  assign hp_arburst = 2'b01;
  assign m_tdata    = hp_rdata;

  assign accept  = (state == IDLE) && cmd_valid;
  assign ar_fire = (state == AR) && hp_arready;
  assign beat    = (state == DATA) && hp_rvalid && m_tready;

  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    hp_arvalid = 1'b0;
    hp_rready  = 1'b0;
    m_tvalid   = 1'b0;
    m_tlast    = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid)
          state_nx = (cmd_len == '0) ? DONE : AR;
      end
      AR: begin
        hp_arvalid = 1'b1;
        if (hp_arready) state_nx = DATA;
      end
      DATA: begin
        hp_rready = m_tready;
        m_tvalid  = hp_rvalid;
        m_tlast   = hp_rlast && (rem == '0);
        if (beat && hp_rlast)
          state_nx = (rem != '0) ? AR : DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr <= {cmd_addr[HP_ADDR_WIDTH-1:4], 4'b0};
        rem  <= cmd_len;
      end else if (ar_fire) begin
        addr <= addr + (HP_ADDR_WIDTH'(blen) << 4);
        rem  <= rem - LEN_WIDTH'(blen);
      end
    end
  end

  logic unused_addr;
  assign unused_addr = ^cmd_addr[3:0];

`ifdef HP_RD_DMA_ERR_EN
  logic err_flag;

  // Sticky across all bursts of a command; cleared on next accept.
  always_ff @(posedge clk) begin
    if (rst)
      err_flag <= 1'b0;
    else if (accept)
      err_flag <= 1'b0;
    else if (beat && (hp_rresp != 2'b00))
      err_flag <= 1'b1;
  end

  assign err = done && err_flag;
`else
  logic unused_resp;
  assign unused_resp = ^hp_rresp;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hp_rd_dma.sv
// Scoreboard bench for hp_rd_dma: directed commands push expected AR,
// beat and done/err entries; a negedge monitor pops and compares.
module tb_hp_rd_dma;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [47:0]  cmd_addr = '0;
  logic [19:0]  cmd_len = '0;
  logic         busy, done, err;
  logic [47:0]  hp_araddr;
  logic [7:0]   hp_arlen;
  logic [2:0]   hp_arsize;
  logic [1:0]   hp_arburst;
  logic         hp_arvalid;
  logic         hp_arready;
  logic [127:0] hp_rdata;
  logic [1:0]   hp_rresp;
  logic         hp_rlast;
  logic         hp_rvalid;
  logic         hp_rready;
  logic [127:0] m_tdata;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;

  always #5 clk = ~clk;

  hp_rd_dma #(.MAX_BURST(64)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .hp_araddr(hp_araddr), .hp_arlen(hp_arlen),
    .hp_arsize(hp_arsize), .hp_arburst(hp_arburst),
    .hp_arvalid(hp_arvalid), .hp_arready(hp_arready),
    .hp_rdata(hp_rdata), .hp_rresp(hp_rresp),
    .hp_rlast(hp_rlast), .hp_rvalid(hp_rvalid),
    .hp_rready(hp_rready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast)
  );

  typedef struct {
    logic [47:0] a;
    logic [7:0]  l;
  } ar_t;

  ar_t          exp_ar[$];
  logic [47:0]  exp_d[$];
  bit           exp_l[$];
  bit           exp_err[$];
  ar_t          sl_q[$];
  ar_t          e;
  int           sl_idx = 0;
  int           cmd_beat = 0;
  int           err_beat = -1;
  int           pass_cnt = 0;
  int           total = 0;
  int           done_cnt = 0;
  bit           mon_en = 1'b1;
  bit           tog_tready = 1'b0;
  bit           tog_arready = 1'b0;

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h",
                  name, act, req);
  endtask

  task automatic push_ar(input logic [47:0] a,
                         input logic [7:0] l);
    ar_t t;
    t.a = a;
    t.l = l;
    exp_ar.push_back(t);
  endtask

  // Monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (mon_en && !rst) begin
      if (hp_arvalid && hp_arready) begin
        if (exp_ar.size() == 0) begin
          chk("ar_unexpected", 1, 0);
        end else begin
          e = exp_ar.pop_front();
          chk("araddr", hp_araddr, e.a);
          chk("arlen", hp_arlen, e.l);
          chk("arsize_burst", {hp_arsize, hp_arburst},
              {3'b100, 2'b01});
          chk("one_outstanding", sl_q.size(), 0);
        end
      end
      if (m_tvalid)
        chk("rready_mirror", hp_rready, m_tready);
      if (m_tvalid && m_tready) begin
        if (exp_d.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          chk("tdata", m_tdata, {80'b0, exp_d.pop_front()});
          chk("tlast", m_tlast, exp_l.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_err.size() == 0)
          chk("done_unexpected", 1, 0);
        else
          chk("err", err, exp_err.pop_front());
      end
    end
  end

  // AXI slave model: data word = byte address of the beat.
  initial begin : slave
    bit          arf, rf, r;
    logic [47:0] sa;
    logic [7:0]  sl;
    ar_t         t;
    hp_arready = 1'b0;
    hp_rvalid  = 1'b0;
    hp_rlast   = 1'b0;
    hp_rdata   = '0;
    hp_rresp   = 2'b00;
    m_tready   = 1'b0;
    forever begin
      @(negedge clk);
      arf = hp_arvalid && hp_arready;
      rf  = hp_rvalid && hp_rready;
      sa  = hp_araddr;
      sl  = hp_arlen;
      r   = rst;
      @(posedge clk);
      #1;
      if (r) begin
        sl_q.delete();
        sl_idx = 0;
      end else begin
        if (rf) begin
          cmd_beat++;
          sl_idx++;
          if (sl_idx > int'(sl_q[0].l)) begin
            void'(sl_q.pop_front());
            sl_idx = 0;
          end
        end
        if (arf) begin
          t.a = sa;
          t.l = sl;
          sl_q.push_back(t);
        end
      end
      if (sl_q.size() > 0) begin
        hp_rvalid = 1'b1;
        hp_rdata  = {80'b0, sl_q[0].a + 48'(sl_idx * 16)};
        hp_rlast  = (sl_idx == int'(sl_q[0].l));
        hp_rresp  = (cmd_beat == err_beat) ? 2'b10 : 2'b00;
      end else begin
        hp_rvalid = 1'b0;
        hp_rlast  = 1'b0;
        hp_rresp  = 2'b00;
      end
      m_tready   = tog_tready ? ~m_tready : 1'b1;
      hp_arready = tog_arready ? ~hp_arready : 1'b1;
    end
  end

  task automatic run_cmd(input logic [47:0] a,
                         input logic [19:0] n,
                         input bit er,
                         output int cyc);
    logic [47:0] base;
    int d0;
    base = {a[47:4], 4'b0};
    for (int i = 0; i < int'(n); i++) begin
      exp_d.push_back(base + 48'(i * 16));
      exp_l.push_back(i == int'(n) - 1);
    end
    exp_err.push_back(er);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    cmd_beat  = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = n;
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (done_cnt == d0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done_cnt != d0, 1);
    chk("ar_drained", exp_ar.size(), 0);
    chk("beats_drained", exp_d.size(), 0);
    @(negedge clk);
    chk("idle_after", {busy, cmd_ready}, 2'b01);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int cyc;
    int k;
    bit any_done;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy_done_err", {busy, done, err}, 3'b000);
    chk("rst_arvalid_rready", {hp_arvalid, hp_rready}, 2'b00);
    chk("rst_tvalid_tlast", {m_tvalid, m_tlast}, 2'b00);
    @(posedge clk);
    #1;
    rst = 1'b0;

    push_ar(48'h1000, 8'd3);
    run_cmd(48'h1000, 20'd4, 1'b0, cyc);

    push_ar(48'h0, 8'd63);
    push_ar(48'h400, 8'd63);
    push_ar(48'h800, 8'd63);
    push_ar(48'hC00, 8'd7);
    run_cmd(48'h0, 20'd200, 1'b0, cyc);

    push_ar(48'hFE0, 8'd1);
    push_ar(48'h1000, 8'd1);
    run_cmd(48'hFE0, 20'd4, 1'b0, cyc);

    push_ar(48'hFF0, 8'd0);
    push_ar(48'h1000, 8'd0);
    run_cmd(48'hFF0, 20'd2, 1'b0, cyc);

    run_cmd(48'h123, 20'd0, 1'b0, cyc);
    chk("len0_latency", cyc <= 3, 1);

    tog_tready  = 1'b1;
    tog_arready = 1'b1;
    push_ar(48'h2000, 8'd9);
    run_cmd(48'h2008, 20'd10, 1'b0, cyc);
    tog_tready  = 1'b0;
    tog_arready = 1'b0;

    push_ar(48'hFFFF_FFFF_FFF0, 8'd0);
    push_ar(48'h0, 8'd0);
    run_cmd(48'hFFFF_FFFF_FFF0, 20'd2, 1'b0, cyc);

`ifdef HP_RD_DMA_ERR_EN
    err_beat = 1;
    push_ar(48'h3000, 8'd3);
    run_cmd(48'h3000, 20'd4, 1'b1, cyc);
    err_beat = -1;
    push_ar(48'h3000, 8'd3);
    run_cmd(48'h3000, 20'd4, 1'b0, cyc);
`endif

    // Reset in the middle of a data phase.
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr  = 48'h0;
    cmd_len   = 20'd8;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_tvalid && k < 50);
    chk("rst_test_reach_data", m_tvalid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_arvalid_rready", {hp_arvalid, hp_rready}, 2'b00);
    chk("midrst_idle", {busy, cmd_ready}, 2'b01);
    any_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (done) any_done = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_done", any_done, 0);
    exp_ar.delete();
    exp_d.delete();
    exp_l.delete();
    exp_err.delete();
    mon_en = 1'b1;

    push_ar(48'h5000, 8'd2);
    run_cmd(48'h5000, 20'd3, 1'b0, cyc);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
